// File: rtl/sl_tx_fifo.sv
// SL line transmitter: queued words serialised MSB first with a parity bit
// onto the two-wire active-low sl0/sl1 bus.
module sl_tx_fifo #(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int WORD_GAP_CYC = 16,
    parameter int PARITY_ODD   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [1:0]                    in_mode,
    input  logic                          abort,
    output logic                          sl0,
    output logic                          sl1,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (PULSE_CYC > GAP_CYC)
        ? ((PULSE_CYC > WORD_GAP_CYC) ? PULSE_CYC : WORD_GAP_CYC)
        : ((GAP_CYC > WORD_GAP_CYC) ? GAP_CYC : WORD_GAP_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] P_END = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] G_END = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] W_END =
        CW'((WORD_GAP_CYC > 0) ? WORD_GAP_CYC - 1 : 0);
    localparam logic PAR_INIT = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_WGAP  = 3'd4;

    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [1:0]        mem_mode_q [FIFO_DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [2:0]      state_q, state_d;
    logic [DATA_W:0] bits_q, bits_d;
    logic [5:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sl0_q, sl0_d, sl1_q, sl1_d, busy_q, busy_d;

    logic            flush, full, push, pop;
    logic [5:0]      len_raw, head_len;
    logic [DATA_W-1:0] head_data, head_mask;
    logic [DATA_W:0] head_bits;

    assign flush    = abort | reset;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    // Word length from the stored mode, clamped; unused high bits masked off.
    always_comb begin
        head_data = mem_data_q[rd_ptr_q];
        len_raw   = {1'b0, mem_mode_q[rd_ptr_q], 3'b000} + 6'd8;
        head_len  = (len_raw > 6'(DATA_W)) ? 6'(DATA_W) : len_raw;
        head_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            head_mask[i] = head_data[i] & (6'(i) < head_len);
        end
        head_bits = {head_mask, (^head_mask) ^ PAR_INIT};
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop     = 1'b1;
                bits_d  = head_bits;
                idx_d   = head_len;
                cnt_d   = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == P_END) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == G_END) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 6'd1;
                        state_d = S_PULSE;
                    end else if (WORD_GAP_CYC == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WGAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WGAP: begin
                if (cnt_q == W_END) begin
                    cnt_d   = '0;
                    state_d = (level_q != '0) ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        // Outputs are registered, so they follow the next state.
        sl0_d  = !((state_d == S_PULSE) && !bits_d[idx_d]);
        sl1_d  = !((state_d == S_PULSE) && bits_d[idx_d]);
        busy_d = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_mode_q[wr_ptr_q] <= in_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            bits_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            sl0_q    <= 1'b1;
            sl1_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            bits_q   <= bits_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sl0_q    <= sl0_d;
            sl1_q    <= sl1_d;
            busy_q   <= busy_d;
        end
    end

    assign sl0        = sl0_q;
    assign sl1        = sl1_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_sl_tx_fifo.sv
// Directed bench for sl_tx_fifo: default, even-parity and 16-bit instances
// share stimulus; a line monitor decodes pulses for each instance.
module tb_sl_tx_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;

    logic       rdy_a, sl0_a, sl1_a, busy_a;
    logic       rdy_b, sl0_b, sl1_b, busy_b;
    logic       rdy_c, sl0_c, sl1_c, busy_c;
    logic [2:0] lvl_a, lvl_b, lvl_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sl_tx_fifo u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_mode(in_mode), .abort(abort),
        .sl0(sl0_a), .sl1(sl1_a), .busy(busy_a), .fifo_level(lvl_a)
    );

    sl_tx_fifo #(.PARITY_ODD(0)) u_even (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_mode(in_mode), .abort(abort),
        .sl0(sl0_b), .sl1(sl1_b), .busy(busy_b), .fifo_level(lvl_b)
    );

    sl_tx_fifo #(.DATA_W(16)) u_w16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data[15:0]), .in_mode(in_mode), .abort(abort),
        .sl0(sl0_c), .sl1(sl1_c), .busy(busy_c), .fifo_level(lvl_c)
    );

    // Line monitor: per pulse records bit, length, start cycle, preceding idle.
    logic [2:0] s0, s1;
    assign s0 = {sl0_c, sl0_b, sl0_a};
    assign s1 = {sl1_c, sl1_b, sl1_a};

    int   cyc = 0;
    int   both_low = 0;
    int   nb  [3] = '{default: 0};
    int   run [3] = '{default: 0};
    int   hi  [3] = '{default: 0};
    logic mbit [3][512];
    int   mlen [3][512];
    int   mpre [3][512];
    int   mst  [3][512];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!s0[k] && !s1[k]) both_low++;
            if (!s0[k] || !s1[k]) begin
                if (run[k] == 0) begin
                    mst[k][nb[k]]  = cyc;
                    mpre[k][nb[k]] = hi[k];
                    mbit[k][nb[k]] = !s1[k];
                    hi[k] = 0;
                end
                run[k]++;
            end else begin
                if (run[k] > 0) begin
                    mlen[k][nb[k]] = run[k];
                    if (nb[k] < 511) nb[k]++;
                    run[k] = 0;
                end
                hi[k]++;
            end
        end
    end

    function automatic logic [63:0] got_bits(input int k, input int b,
                                             input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], mbit[k][b+i]};
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        in_data = d;
        in_mode = m;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_all(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy_a && !busy_b && !busy_c) break;
            tick();
        end
        checks++;
        if (i >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles", nm, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h5A;
        tick();
        checks++;
        if (rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b exp 0", rdy_a);
        end
        checks++;
        if ({sl0_a, sl1_a} !== 2'b11) begin
            errors++;
            $display("FAIL reset_lines: got %b exp 11", {sl0_a, sl1_a});
        end
        checks++;
        if ({busy_a, lvl_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_busy_level: got %b exp 0000", {busy_a, lvl_a});
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b exp 1", rdy_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_word: busy got %b exp 0", busy_a);
        end
    endtask

    task automatic test_basic();
        int b, c0, fall, bad;
        do_reset();
        b = nb[0];
        c0 = cyc;
        push(32'h86, 2'd0);
        checks++;
        if (lvl_a !== 3'd1) begin
            errors++;
            $display("FAIL basic_level: got %0d exp 1", lvl_a);
        end
        fall = -1;
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) begin
                fall = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (fall != c0 + 91) begin
            errors++;
            $display("FAIL basic_busy_fall: got %0d exp %0d", fall - c0, 91);
        end
        checks++;
        if (nb[0] - b != 9) begin
            errors++;
            $display("FAIL basic_nbits: got %0d exp 9", nb[0] - b);
        end
        checks++;
        if (got_bits(0, b, 9) !== 64'h10C) begin
            errors++;
            $display("FAIL basic_bits: got %0h exp 10c", got_bits(0, b, 9));
        end
        checks++;
        if (mst[0][b] != c0 + 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d exp 3", mst[0][b] - c0);
        end
        bad = 0;
        for (int j = 0; j < 9; j++) begin
            if (mlen[0][b+j] != 4) bad++;
            if (j > 0 && mpre[0][b+j] != 4) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_cell_timing: got %0d bad cells exp 0", bad);
        end
    endtask

    task automatic test_parity();
        int b0, b1;
        do_reset();
        b0 = nb[0];
        b1 = nb[1];
        push(32'hFFFF_FFFF, 2'd3);
        wait_all(400, "parity");
        checks++;
        if (nb[0] - b0 != 33 || nb[1] - b1 != 33) begin
            errors++;
            $display("FAIL parity_nbits: got %0d/%0d exp 33/33",
                     nb[0] - b0, nb[1] - b1);
        end
        checks++;
        if (got_bits(0, b0, 33) !== 64'h1_FFFF_FFFF) begin
            errors++;
            $display("FAIL parity_odd_bits: got %0h exp 1ffffffff",
                     got_bits(0, b0, 33));
        end
        checks++;
        if (got_bits(1, b1, 33) !== 64'h1_FFFF_FFFE) begin
            errors++;
            $display("FAIL parity_even_bits: got %0h exp 1fffffffe",
                     got_bits(1, b1, 33));
        end
        checks++;
        if (both_low != 0) begin
            errors++;
            $display("FAIL parity_both_low: got %0d exp 0", both_low);
        end
    endtask

    task automatic test_width();
        int b0, b2;
        do_reset();
        b0 = nb[0];
        b2 = nb[2];
        push(32'h0000_A5F0, 2'd2);
        wait_all(400, "width");
        checks++;
        if (nb[2] - b2 != 17) begin
            errors++;
            $display("FAIL width_nbits: got %0d exp 17", nb[2] - b2);
        end
        checks++;
        if (got_bits(2, b2, 17) !== 64'h14BE1) begin
            errors++;
            $display("FAIL width_bits: got %0h exp 14be1", got_bits(2, b2, 17));
        end
        checks++;
        if (mbit[2][b2+16] !== 1'b1) begin
            errors++;
            $display("FAIL width_parity: got %b exp 1", mbit[2][b2+16]);
        end
        checks++;
        if (nb[0] - b0 != 25 || got_bits(0, b0, 25) !== 64'h14BE1) begin
            errors++;
            $display("FAIL width_24bit: got %0d bits %0h exp 25 bits 14be1",
                     nb[0] - b0, got_bits(0, b0, 25));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5] = '{32'h01, 32'h80, 32'hFF, 32'h00, 32'h3C};
        logic [8:0] ex [6] = '{9'h10C, 9'h002, 9'h100, 9'h1FF, 9'h001, 9'h079};
        int b, c0, rise;
        do_reset();
        b = nb[0];
        c0 = cyc;
        push(32'h86, 2'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) push(w[i], 2'd0);
        in_valid = 1'b1;
        in_data = w[4];
        checks++;
        if (lvl_a !== 3'd4 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: level %0d ready %b exp 4 0", lvl_a, rdy_a);
        end
        rise = -1;
        for (int i = 0; i < 200; i++) begin
            if (rdy_a) begin
                rise = cyc;
                break;
            end
            tick();
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (rise != c0 + 92) begin
            errors++;
            $display("FAIL fill_ready_rise: got %0d exp 92", rise - c0);
        end
        wait_all(800, "fill");
        checks++;
        if (nb[0] - b != 54) begin
            errors++;
            $display("FAIL fill_nbits: got %0d exp 54", nb[0] - b);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got_bits(0, b + 9 * k, 9) !== {55'd0, ex[k]}) begin
                errors++;
                $display("FAIL fill_word%0d: got %0h exp %0h",
                         k, got_bits(0, b + 9 * k, 9), ex[k]);
            end
            if (k > 0) begin
                checks++;
                if (mpre[0][b + 9 * k] != 21) begin
                    errors++;
                    $display("FAIL fill_gap%0d: got %0d exp 21",
                             k, mpre[0][b + 9 * k]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int b, c0;
        do_reset();
        b = nb[0];
        c0 = cyc;
        push(32'h86, 2'd0);
        push(32'h01, 2'd0);
        push(32'h80, 2'd0);
        while (cyc < c0 + 20) tick();
        checks++;
        if ({sl0_a, sl1_a, lvl_a} !== 5'b01010) begin
            errors++;
            $display("FAIL abort_pre: got %b exp 01010", {sl0_a, sl1_a, lvl_a});
        end
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55;
        #1;
        checks++;
        if (rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: got %b exp 0", rdy_a);
        end
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({sl0_a, sl1_a, busy_a, lvl_a} !== 6'b110000) begin
            errors++;
            $display("FAIL abort_state: got %b exp 110000",
                     {sl0_a, sl1_a, busy_a, lvl_a});
        end
        repeat (30) tick();
        checks++;
        if (busy_a !== 1'b0 || nb[0] - b != 3) begin
            errors++;
            $display("FAIL abort_quiet: busy %b pulses %0d exp 0 3",
                     busy_a, nb[0] - b);
        end
    endtask

    task automatic test_reset_mid();
        int b, c0, c1;
        do_reset();
        c0 = cyc;
        push(32'h86, 2'd0);
        while (cyc < c0 + 20) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({sl0_a, sl1_a, busy_a, lvl_a} !== 6'b110000) begin
            errors++;
            $display("FAIL rstmid_state: got %b exp 110000",
                     {sl0_a, sl1_a, busy_a, lvl_a});
        end
        reset = 1'b0;
        b = nb[0];
        c1 = cyc;
        push(32'h01, 2'd0);
        wait_all(200, "rstmid");
        checks++;
        if (mst[0][b] != c1 + 3) begin
            errors++;
            $display("FAIL rstmid_latency: got %0d exp 3", mst[0][b] - c1);
        end
        checks++;
        if (nb[0] - b != 9 || got_bits(0, b, 9) !== 64'h002) begin
            errors++;
            $display("FAIL rstmid_bits: got %0d bits %0h exp 9 bits 002",
                     nb[0] - b, got_bits(0, b, 9));
        end
        checks++;
        if (both_low != 0) begin
            errors++;
            $display("FAIL final_both_low: got %0d exp 0", both_low);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_width();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
